// File: rtl/mem_access_ctrl.sv
// MEM-stage access sequencer: region decode, DMEM/IMEM strobes, UART I/O,
// cycle/instret counters and the one-cycle-late aligned load return.
//
// Ports:
//   clk, rst (async, active-low)
//   stall, mem_re, mem_we, funct3, addr, wdata, pc, retire : MEM-stage inputs
//   dmem_*  : DMEM port (en, byte strobes, word address, write data, dout)
//   imem_*  : IMEM write port (en, byte strobes, word address, write data)
//   uart_*  : UART tx/rx ready-valid handshakes
//   load_data : aligned and extended load result, valid in WB (T+1)
module mem_access_ctrl #(
    parameter int          ADDR_W  = 14,
    parameter logic [31:0] IO_BASE = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic [31:0]       pc,
    input  logic              retire,
    input  logic [31:0]       dmem_dout,
    output logic              dmem_en,
    output logic [3:0]        dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_din,
    output logic              imem_en,
    output logic [3:0]        imem_wea,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_din,
    input  logic              uart_tx_ready,
    output logic              uart_tx_valid,
    output logic [7:0]        uart_tx_data,
    input  logic              uart_rx_valid,
    input  logic [7:0]        uart_rx_data,
    output logic              uart_rx_ready,
    output logic [31:0]       load_data
);

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_DMEM = 2'd1,
        SRC_IO   = 2'd2
    } src_e;

    localparam logic [31:0] OFF_STATUS = 32'h00;
    localparam logic [31:0] OFF_RXDATA = 32'h04;
    localparam logic [31:0] OFF_TXDATA = 32'h08;
    localparam logic [31:0] OFF_CYCLE  = 32'h10;
    localparam logic [31:0] OFF_INST   = 32'h14;
    localparam logic [31:0] OFF_CLEAR  = 32'h18;

    logic [3:0]  region;
    logic        access;
    logic        is_ld;
    logic        is_st;
    logic        in_dmem;
    logic        in_imem;
    logic        in_io;
    logic [31:0] io_off;
    logic [3:0]  strb;
    logic [31:0] din_rep;
    logic [31:0] io_rdata;
    logic        cnt_clr;
    src_e        next_src;

    logic [31:0] cycle_cnt;
    logic [31:0] inst_cnt;
    src_e        src_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] io_q;

    logic [31:0] ld_word;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    // Only pc[30] qualifies IMEM writes; the rest of the PC is irrelevant here.
    logic unused_pc;
    assign unused_pc = ^{pc[31], pc[29:0]};

    // Outputs are gated by rst so nothing is strobed while reset is held.
    assign region  = addr[31:28];
    assign access  = rst && !stall && (mem_re || mem_we);
    assign is_ld   = access && mem_re;
    assign is_st   = access && mem_we;
    assign in_dmem = (region == 4'b0001) || (region == 4'b0011);
    assign in_imem = ((region == 4'b0010) || (region == 4'b0011)) && pc[30];
    assign in_io   = addr[31];
    assign io_off  = addr - IO_BASE;

    always_comb begin
        strb    = 4'b0000;
        din_rep = wdata;
        case (funct3[1:0])
            2'b00: begin
                strb    = 4'b0001 << addr[1:0];
                din_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                strb    = 4'b0011 << {addr[1], 1'b0};
                din_rep = {2{wdata[15:0]}};
            end
            2'b10: begin
                strb    = 4'b1111;
                din_rep = wdata;
            end
            default: begin
                strb    = 4'b0000;
                din_rep = wdata;
            end
        endcase
    end

    assign dmem_en   = access && in_dmem;
    assign dmem_we   = (is_st && in_dmem) ? strb : 4'b0000;
    assign dmem_addr = addr[ADDR_W+1:2];
    assign dmem_din  = din_rep;

    assign imem_en   = is_st && in_imem;
    assign imem_wea  = imem_en ? strb : 4'b0000;
    assign imem_addr = addr[ADDR_W+1:2];
    assign imem_din  = din_rep;

    // A tx byte offered while the UART is busy is simply dropped.
    assign uart_tx_valid = is_st && in_io && (io_off == OFF_TXDATA)
                           && uart_tx_ready;
    assign uart_tx_data  = wdata[7:0];
    assign uart_rx_ready = is_ld && in_io && (io_off == OFF_RXDATA)
                           && uart_rx_valid;

    assign cnt_clr = is_st && in_io && (io_off == OFF_CLEAR);

    always_comb begin
        io_rdata = 32'h0;
        case (io_off)
            OFF_STATUS: io_rdata = {30'b0, uart_rx_valid, uart_tx_ready};
            OFF_RXDATA: io_rdata = {24'b0, uart_rx_data};
            OFF_CYCLE:  io_rdata = cycle_cnt;
            OFF_INST:   io_rdata = inst_cnt;
            default:    io_rdata = 32'h0;
        endcase
    end

    always_comb begin
        next_src = SRC_NONE;
        if (is_ld) begin
            if (in_io) begin
                next_src = SRC_IO;
            end else if (in_dmem) begin
                next_src = SRC_DMEM;
            end else begin
                next_src = SRC_NONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= 32'h0;
            inst_cnt  <= 32'h0;
        end else if (cnt_clr) begin
            cycle_cnt <= 32'h0;
            inst_cnt  <= 32'h0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            inst_cnt  <= inst_cnt + {31'b0, retire};
        end
    end

    // Pending-load state holds across a stall, keeping load_data stable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q <= SRC_NONE;
            f3_q  <= 3'b000;
            off_q <= 2'b00;
            io_q  <= 32'h0;
        end else if (!stall) begin
            src_q <= next_src;
            f3_q  <= funct3;
            off_q <= addr[1:0];
            io_q  <= io_rdata;
        end
    end

    always_comb begin
        ld_word = 32'h0;
        case (src_q)
            SRC_DMEM: ld_word = dmem_dout;
            SRC_IO:   ld_word = io_q;
            default:  ld_word = 32'h0;
        endcase
    end

    assign ld_b = ld_word[{off_q, 3'b000} +: 8];
    assign ld_h = ld_word[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        load_data = ld_word;
        case (f3_q)
            3'b000:  load_data = {{24{ld_b[7]}}, ld_b};
            3'b001:  load_data = {{16{ld_h[15]}}, ld_h};
            3'b100:  load_data = {24'b0, ld_b};
            3'b101:  load_data = {16'b0, ld_h};
            default: load_data = ld_word;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table for single accesses,
// hand sequences for UART, counters, stall and reset.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        mem_re;
    logic        mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        retire;
    logic [31:0] dmem_dout;
    logic        dmem_en;
    logic [3:0]  dmem_we;
    logic [13:0] dmem_addr;
    logic [31:0] dmem_din;
    logic        imem_en;
    logic [3:0]  imem_wea;
    logic [13:0] imem_addr;
    logic [31:0] imem_din;
    logic        uart_tx_ready;
    logic        uart_tx_valid;
    logic [7:0]  uart_tx_data;
    logic        uart_rx_valid;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_ready;
    logic [31:0] load_data;

    int n_run;
    int n_fail;

    mem_access_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .mem_re        (mem_re),
        .mem_we        (mem_we),
        .funct3        (funct3),
        .addr          (addr),
        .wdata         (wdata),
        .pc            (pc),
        .retire        (retire),
        .dmem_dout     (dmem_dout),
        .dmem_en       (dmem_en),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_din      (dmem_din),
        .imem_en       (imem_en),
        .imem_wea      (imem_wea),
        .imem_addr     (imem_addr),
        .imem_din      (imem_din),
        .uart_tx_ready (uart_tx_ready),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_data  (uart_tx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_ready (uart_rx_ready),
        .load_data     (load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        re;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [31:0] dout;
        logic        en;
        logic [3:0]  wes;
        logic [13:0] wa;
        logic [31:0] din;
        logic        im_en;
        logic [3:0]  wea;
        logic [31:0] ld;
    } vec_t;

    localparam int NV = 15;
    vec_t tv [NV];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        stall  = 1'b0;
        mem_re = 1'b0;
        mem_we = 1'b0;
        funct3 = 3'b000;
        addr   = 32'h0;
        wdata  = 32'h0;
        pc     = 32'h0;
        retire = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ld_w(input logic [31:0] a);
        mem_re = 1'b1;
        mem_we = 1'b0;
        funct3 = 3'b010;
        addr   = a;
    endtask

    task automatic st_w(input logic [31:0] a, input logic [31:0] d);
        mem_re = 1'b0;
        mem_we = 1'b1;
        funct3 = 3'b010;
        addr   = a;
        wdata  = d;
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;

        tv[0]  = '{1'b0, 1'b0, 1'b1, 3'b000, 32'h1000_0006, 32'h1234_56AB,
                   32'h0, 32'h0, 1'b1, 4'b0100, 14'd1, 32'hABAB_ABAB,
                   1'b0, 4'b0000, 32'h0};
        tv[1]  = '{1'b0, 1'b1, 1'b0, 3'b000, 32'h1000_0006, 32'h0,
                   32'h0, 32'h00AB_0000, 1'b1, 4'b0000, 14'd1, 32'h0,
                   1'b0, 4'b0000, 32'hFFFF_FFAB};
        tv[2]  = '{1'b0, 1'b1, 1'b0, 3'b100, 32'h1000_0006, 32'h0,
                   32'h0, 32'h00AB_0000, 1'b1, 4'b0000, 14'd1, 32'h0,
                   1'b0, 4'b0000, 32'h0000_00AB};
        tv[3]  = '{1'b0, 1'b0, 1'b1, 3'b010, 32'h3000_0010, 32'hDEAD_BEEF,
                   32'h4000_0000, 32'h0, 1'b1, 4'b1111, 14'd4, 32'hDEAD_BEEF,
                   1'b1, 4'b1111, 32'h0};
        tv[4]  = '{1'b0, 1'b0, 1'b1, 3'b010, 32'h3000_0010, 32'hDEAD_BEEF,
                   32'h0, 32'h0, 1'b1, 4'b1111, 14'd4, 32'hDEAD_BEEF,
                   1'b0, 4'b0000, 32'h0};
        tv[5]  = '{1'b0, 1'b0, 1'b1, 3'b001, 32'h1000_0003, 32'h0000_BEEF,
                   32'h0, 32'h0, 1'b1, 4'b1100, 14'd0, 32'hBEEF_BEEF,
                   1'b0, 4'b0000, 32'h0};
        tv[6]  = '{1'b0, 1'b1, 1'b0, 3'b010, 32'h1000_0008, 32'h0,
                   32'h0, 32'h1234_5678, 1'b1, 4'b0000, 14'd2, 32'h0,
                   1'b0, 4'b0000, 32'h1234_5678};
        tv[7]  = '{1'b0, 1'b1, 1'b0, 3'b101, 32'h1000_0002, 32'h0,
                   32'h0, 32'h8001_0000, 1'b1, 4'b0000, 14'd0, 32'h0,
                   1'b0, 4'b0000, 32'h0000_8001};
        tv[8]  = '{1'b0, 1'b1, 1'b0, 3'b001, 32'h1000_0000, 32'h0,
                   32'h0, 32'h0000_8001, 1'b1, 4'b0000, 14'd0, 32'h0,
                   1'b0, 4'b0000, 32'hFFFF_8001};
        tv[9]  = '{1'b1, 1'b0, 1'b1, 3'b010, 32'h1000_0000, 32'h0,
                   32'h0, 32'h0, 1'b0, 4'b0000, 14'd0, 32'h0,
                   1'b0, 4'b0000, 32'h0};
        tv[10] = '{1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0,
                   32'h0, 32'hFFFF_FFFF, 1'b0, 4'b0000, 14'd16, 32'h0,
                   1'b0, 4'b0000, 32'h0};
        tv[11] = '{1'b0, 1'b0, 1'b1, 3'b010, 32'h2000_0000, 32'h1122_3344,
                   32'h4000_0000, 32'h0, 1'b0, 4'b0000, 14'd0, 32'h1122_3344,
                   1'b1, 4'b1111, 32'h0};
        tv[12] = '{1'b0, 1'b1, 1'b0, 3'b010, 32'h2000_0004, 32'h0,
                   32'h0, 32'hFFFF_FFFF, 1'b0, 4'b0000, 14'd1, 32'h0,
                   1'b0, 4'b0000, 32'h0};
        tv[13] = '{1'b0, 1'b1, 1'b0, 3'b000, 32'h1000_0001, 32'h0,
                   32'h0, 32'h0000_7F00, 1'b1, 4'b0000, 14'd0, 32'h0,
                   1'b0, 4'b0000, 32'h0000_007F};
        tv[14] = '{1'b0, 1'b1, 1'b0, 3'b101, 32'h1000_0003, 32'h0,
                   32'h0, 32'hCAFE_0000, 1'b1, 4'b0000, 14'd0, 32'h0,
                   1'b0, 4'b0000, 32'h0000_CAFE};

        idle();
        rst           = 1'b0;
        dmem_dout     = 32'h0;
        uart_tx_ready = 1'b0;
        uart_rx_valid = 1'b0;
        uart_rx_data  = 8'h00;

        // Reset state, including a store attempted while reset is held.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_dmem_en", {31'b0, dmem_en}, 32'h0);
        chk("rst_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
        chk("rst_rx_ready", {31'b0, uart_rx_ready}, 32'h0);
        st_w(32'h1000_0000, 32'h1);
        #1;
        chk("rst_store_we", {28'b0, dmem_we}, 32'h0);
        chk("rst_store_en", {31'b0, dmem_en}, 32'h0);
        @(negedge clk);
        idle();
        rst = 1'b1;
        cyc();

        // Single-access vector table.
        for (int i = 0; i < NV; i++) begin
            stall     = tv[i].stall;
            mem_re    = tv[i].re;
            mem_we    = tv[i].we;
            funct3    = tv[i].f3;
            addr      = tv[i].addr;
            wdata     = tv[i].wdata;
            pc        = tv[i].pc;
            dmem_dout = 32'hDEAD_DEAD;
            #1;
            chk($sformatf("v%0d_dmem_en", i), {31'b0, dmem_en},
                {31'b0, tv[i].en});
            chk($sformatf("v%0d_dmem_we", i), {28'b0, dmem_we},
                {28'b0, tv[i].wes});
            chk($sformatf("v%0d_dmem_addr", i), {18'b0, dmem_addr},
                {18'b0, tv[i].wa});
            chk($sformatf("v%0d_dmem_din", i), dmem_din, tv[i].din);
            chk($sformatf("v%0d_imem_en", i), {31'b0, imem_en},
                {31'b0, tv[i].im_en});
            chk($sformatf("v%0d_imem_wea", i), {28'b0, imem_wea},
                {28'b0, tv[i].wea});
            chk($sformatf("v%0d_imem_addr", i), {18'b0, imem_addr},
                {18'b0, tv[i].wa});
            chk($sformatf("v%0d_imem_din", i), imem_din, tv[i].din);
            cyc();
            idle();
            dmem_dout = tv[i].dout;
            #1;
            chk($sformatf("v%0d_load_data", i), load_data, tv[i].ld);
            cyc();
        end

        // UART transmit: accepted, then dropped when not ready.
        uart_tx_ready = 1'b1;
        st_w(32'h8000_0008, 32'h0000_0041);
        #1;
        chk("tx_valid", {31'b0, uart_tx_valid}, 32'h1);
        chk("tx_data", {24'b0, uart_tx_data}, 32'h41);
        chk("tx_dmem_en", {31'b0, dmem_en}, 32'h0);
        cyc();
        idle();
        #1;
        chk("tx_valid_after", {31'b0, uart_tx_valid}, 32'h0);
        cyc();
        uart_tx_ready = 1'b0;
        st_w(32'h8000_0008, 32'h0000_0042);
        #1;
        chk("tx_valid_busy", {31'b0, uart_tx_valid}, 32'h0);
        cyc();
        idle();

        // UART status and receive pop.
        uart_tx_ready = 1'b1;
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h5A;
        ld_w(32'h8000_0000);
        #1;
        chk("status_rx_ready", {31'b0, uart_rx_ready}, 32'h0);
        cyc();
        idle();
        #1;
        chk("status_read", load_data, 32'h3);
        ld_w(32'h8000_0004);
        #1;
        chk("rx_ready_pulse", {31'b0, uart_rx_ready}, 32'h1);
        cyc();
        idle();
        #1;
        chk("rx_ready_after", {31'b0, uart_rx_ready}, 32'h0);
        chk("rx_data_read", load_data, 32'h5A);
        cyc();
        uart_rx_valid = 1'b0;
        uart_tx_ready = 1'b0;

        // Counter clear beats a simultaneous retire.
        st_w(32'h8000_0018, 32'h0);
        retire = 1'b1;
        cyc();
        idle();
        ld_w(32'h8000_0014);
        cyc();
        idle();
        #1;
        chk("inst_after_clear", load_data, 32'h0);
        ld_w(32'h8000_0010);
        cyc();
        idle();
        #1;
        chk("cycle_after_clear", load_data, 32'h1);
        cyc();

        // 10 cycles with 4 retires after a clear.
        st_w(32'h8000_0018, 32'h0);
        cyc();
        for (int i = 0; i < 10; i++) begin
            idle();
            retire = (i % 3 == 0);
            cyc();
        end
        idle();
        ld_w(32'h8000_0014);
        cyc();
        idle();
        ld_w(32'h8000_0010);
        #1;
        chk("inst_count", load_data, 32'd4);
        cyc();
        idle();
        #1;
        chk("cycle_count", load_data, 32'd11);
        cyc();

        // Stall holds the pending halfword load.
        mem_re = 1'b1;
        funct3 = 3'b001;
        addr   = 32'h1000_0002;
        #1;
        chk("stall_issue_en", {31'b0, dmem_en}, 32'h1);
        cyc();
        stall     = 1'b1;
        dmem_dout = 32'h8123_4567;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall%0d_load", i), load_data, 32'hFFFF_8123);
            chk($sformatf("stall%0d_en", i), {31'b0, dmem_en}, 32'h0);
            chk($sformatf("stall%0d_we", i), {28'b0, dmem_we}, 32'h0);
            cyc();
        end
        idle();
        cyc();

        // Reset between T and T+1 of a load.
        ld_w(32'h1000_0000);
        cyc();
        idle();
        dmem_dout = 32'h1234_5678;
        #1;
        chk("pre_reset_load", load_data, 32'h1234_5678);
        rst = 1'b0;
        #1;
        chk("reset_load_zero", load_data, 32'h0);
        st_w(32'h8000_0008, 32'h0000_0055);
        uart_tx_ready = 1'b1;
        #1;
        chk("reset_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
        st_w(32'h1000_0000, 32'h1);
        #1;
        chk("reset_we", {28'b0, dmem_we}, 32'h0);
        chk("reset_en", {31'b0, dmem_en}, 32'h0);
        idle();
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk("release_load_zero", load_data, 32'h0);
        chk("release_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
        ld_w(32'h8000_0010);
        cyc();
        idle();
        #1;
        chk("release_cycle", load_data, 32'h0);
        ld_w(32'h8000_0014);
        cyc();
        idle();
        #1;
        chk("release_inst", load_data, 32'h0);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
